// File: rtl/fifo_wr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : definitions (package)
// Description : Shared widths, widle activity codes and write-FSM state type
//               for the asynchronous FIFO write side.
// Revision    : 1.0 - initial release
// ============================================================================
package definitions;

    localparam int ADDRSIZE = 10;
    localparam int DATASIZE = 8;

    // Write-side activity codes reported to fifo_ack
    localparam logic [1:0] WIDLE_ACT   = 2'b00;
    localparam logic [1:0] WIDLE_SHORT = 2'b01;
    localparam logic [1:0] WIDLE_LONG  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_ctrl_idle_mon.sv
`default_nettype none
// ============================================================================
// Module      : wr_idle_mon
// Description : Saturating idle-cycle counter and widle activity encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_idle_mon
    import definitions::*;
#(
    parameter int unsigned IDLE_LONG = 64
) (
    input  logic       wclk,
    input  logic       wrst,
    input  logic       in_idle,
    output logic [1:0] widle
);

    logic [7:0] icnt;

    // Count consecutive idle cycles, saturating at the 8-bit maximum
    always_ff @(posedge wclk) begin
        if (wrst) begin
            icnt <= 8'd0;
        end else if (!in_idle) begin
            icnt <= 8'd0;
        end else if (icnt != 8'hFF) begin
            icnt <= icnt + 8'd1;
        end
    end

    // Encode activity straight from the current state, no extra latency
    always_comb begin
        widle = WIDLE_ACT;
        if (in_idle) begin
            if ({24'd0, icnt} >= 32'(IDLE_LONG)) begin
                widle = WIDLE_LONG;
            end else begin
                widle = WIDLE_SHORT;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Write-side burst controller for the asynchronous FIFO.
//               Requests space from fifo_ack, streams a burst into the FIFO
//               memory once granted, and reports write-side idleness.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
    import definitions::*;
#(
    parameter int          ADDRSIZE  = definitions::ADDRSIZE,
    parameter int          DATASIZE  = definitions::DATASIZE,
    parameter int unsigned IDLE_LONG = 64
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                burst_start,
    input  logic [7:0]          burst_len,
    input  logic                src_valid,
    input  logic [DATASIZE-1:0] src_data,
    output logic                src_ready,
    input  logic                wack,
    input  logic                wfull,
    output logic                wen,
    output logic                winc,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [DATASIZE-1:0] wdata,
    output logic [ADDRSIZE-1:0] wptr,
    output logic [1:0]          widle,
    output logic                burst_done
);

    wr_state_t           state;
    logic [8:0]          len_q;
    logic [8:0]          cnt;
    logic                w_write;

    // A word moves only while granted, offered and the FIFO has room
    always_comb begin
        w_write = (state == WRITE) && src_valid && !wfull;
    end

    // Burst FSM, burst length/progress and write pointer
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state <= IDLE;
            len_q <= 9'd0;
            cnt   <= 9'd0;
            wptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (burst_start) begin
                        // A zero length field encodes the maximum burst of 256
                        len_q <= (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
                        cnt   <= 9'd0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (wack) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_write) begin
                        wptr <= wptr + 1'b1;
                        cnt  <= cnt + 9'd1;
                        if (cnt == len_q - 9'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and memory-port outputs decoded from the state
    always_comb begin
        wen        = (state == REQ) || (state == WRITE);
        winc       = w_write;
        src_ready  = w_write;
        burst_done = (state == DONE);
        waddr      = wptr;
        wdata      = src_data;
    end

    wr_idle_mon #(
        .IDLE_LONG (IDLE_LONG)
    ) u_idle_mon (
        .wclk    (wclk),
        .wrst    (wrst),
        .in_idle (state == IDLE),
        .widle   (widle)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_ctrl
// Description : Self-checking bench for fifo_wr_ctrl. A pointer/word-count
//               reference model predicts addresses, strobes and handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       burst_start;
    logic [7:0] burst_len;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       wack;
    logic       wfull;
    logic       wen;
    logic       winc;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic [9:0] wptr;
    logic [1:0] widle;
    logic       burst_done;

    int checks = 0;
    int errors = 0;
    int exp_ptr = 0;   // reference write pointer, kept modulo 1024

    fifo_wr_ctrl dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .wack        (wack),
        .wfull       (wfull),
        .wen         (wen),
        .winc        (winc),
        .waddr       (waddr),
        .wdata       (wdata),
        .wptr        (wptr),
        .widle       (widle),
        .burst_done  (burst_done)
    );

    always #5 wclk = ~wclk;

    // Advance past the next rising edge; inputs are driven from here
    task automatic cyc();
        @(posedge wclk);
        #1;
    endtask

    // One burst: issue, wait for grant, stream n words, observe completion.
    // Returns the number of cycles spent between grant and burst_done.
    task automatic run_burst(input int len_field, input int wack_dly,
                             input int stall_at, input int stall_cyc,
                             input bit rand_valid, input bit poke,
                             output int wr_cycles);
        int  n;
        int  written;
        int  stall_left;
        int  budget;
        bit  exp_w;
        n          = (len_field == 0) ? 256 : len_field;
        written    = 0;
        stall_left = stall_cyc;
        wr_cycles  = 0;

        burst_start = 1'b1;
        burst_len   = 8'(len_field);
        @(negedge wclk);
        checks++;
        if (wen !== 1'b0) begin errors++; $display("FAIL start_wen actual=%b required=0", wen); end
        cyc();
        burst_start = 1'b0;
        burst_len   = 8'($urandom);

        for (int d = 0; d <= wack_dly; d++) begin
            wack        = (d == wack_dly);
            burst_start = poke && (d == 0);
            @(negedge wclk);
            checks++;
            if (wen !== 1'b1 || winc !== 1'b0 || widle !== 2'b00) begin
                errors++;
                $display("FAIL req_phase actual wen=%b winc=%b widle=%b required 1 0 00", wen, winc, widle);
            end
            cyc();
        end
        wack        = 1'b0;
        burst_start = 1'b0;

        budget = 0;
        while (written < n) begin
            if (budget > 5000) begin
                errors++;
                $display("FAIL write_timeout actual=%0d required=%0d", written, n);
                break;
            end
            budget++;
            src_valid   = rand_valid ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            src_data    = 8'($urandom);
            wfull       = (written >= stall_at) && (stall_left > 0);
            burst_start = poke && (budget == 1);
            wack        = 1'($urandom);
            exp_w       = src_valid && !wfull;
            @(negedge wclk);
            checks++;
            if (winc !== exp_w || src_ready !== exp_w || wen !== 1'b1 || burst_done !== 1'b0) begin
                errors++;
                $display("FAIL write_ctl actual winc=%b rdy=%b wen=%b done=%b required winc=%b rdy=%b wen=1 done=0",
                         winc, src_ready, wen, burst_done, exp_w, exp_w);
            end
            checks++;
            if (wptr !== 10'(exp_ptr) || (exp_w && (waddr !== 10'(exp_ptr) || wdata !== src_data))) begin
                errors++;
                $display("FAIL write_addr actual wptr=%0d waddr=%0d wdata=%h required %0d %0d %h",
                         wptr, waddr, wdata, exp_ptr, exp_ptr, src_data);
            end
            if (exp_w) begin
                exp_ptr = (exp_ptr + 1) % 1024;
                written++;
            end
            if (wfull) stall_left--;
            wr_cycles++;
            cyc();
        end
        src_valid   = 1'b0;
        wfull       = 1'b0;
        wack        = 1'b0;
        burst_start = 1'b0;

        @(negedge wclk);
        checks++;
        if (burst_done !== 1'b1 || wen !== 1'b0 || winc !== 1'b0 || widle !== 2'b00) begin
            errors++;
            $display("FAIL done_cycle actual done=%b wen=%b winc=%b widle=%b required 1 0 0 00",
                     burst_done, wen, winc, widle);
        end
        cyc();
        @(negedge wclk);
        checks++;
        if (burst_done !== 1'b0 || wen !== 1'b0 || widle !== 2'b01 || wptr !== 10'(exp_ptr)) begin
            errors++;
            $display("FAIL back_idle actual done=%b wen=%b widle=%b wptr=%0d required 0 0 01 %0d",
                     burst_done, wen, widle, wptr, exp_ptr);
        end
        cyc();
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        cyc();
        cyc();
        wrst = 1'b0;
        exp_ptr = 0;
        @(negedge wclk);
        checks++;
        if (wen !== 0 || winc !== 0 || src_ready !== 0 || wptr !== 0 || widle !== 2'b01 || burst_done !== 0) begin
            errors++;
            $display("FAIL reset_vals actual wen=%b winc=%b rdy=%b wptr=%0d widle=%b done=%b required 0 0 0 0 01 0",
                     wen, winc, src_ready, wptr, widle, burst_done);
        end
        for (int j = 1; j <= 70; j++) begin
            cyc();
            @(negedge wclk);
            checks++;
            if (widle !== ((j >= 64) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL idle_mon j=%0d actual=%b required=%b", j, widle, (j >= 64) ? 2'b10 : 2'b01);
            end
        end
        cyc();
    endtask

    task automatic test_basic();
        int c;
        int p0;
        p0 = exp_ptr;
        run_burst(4, 3, 999, 0, 1'b0, 1'b0, c);
        checks++;
        if (c !== 4 || exp_ptr !== p0 + 4) begin
            errors++;
            $display("FAIL basic_len actual cycles=%0d ptr=%0d required 4 %0d", c, exp_ptr, p0 + 4);
        end
    endtask

    task automatic test_full_stall();
        int c;
        run_burst(8, 1, 3, 5, 1'b0, 1'b0, c);
        checks++;
        if (c !== 13) begin
            errors++;
            $display("FAIL stall_cycles actual=%0d required=13", c);
        end
    endtask

    task automatic test_ignored();
        int c;
        run_burst(5, 2, 999, 0, 1'b0, 1'b1, c);
        checks++;
        if (c !== 5) begin
            errors++;
            $display("FAIL ignored_start actual=%0d required=5", c);
        end
        wack = 1'b1;
        cyc();
        wack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            checks++;
            if (wen !== 1'b0 || winc !== 1'b0 || widle !== 2'b01) begin
                errors++;
                $display("FAIL ignored_wack actual wen=%b winc=%b widle=%b required 0 0 01", wen, winc, widle);
            end
            cyc();
        end
    endtask

    task automatic test_wrap();
        int c;
        int rem;
        rem = (1022 - exp_ptr + 1024) % 1024;
        while (rem > 0) begin
            run_burst((rem > 255) ? 255 : rem, 0, 999, 0, 1'b0, 1'b0, c);
            rem = (1022 - exp_ptr + 1024) % 1024;
        end
        checks++;
        if (wptr !== 10'd1022) begin
            errors++;
            $display("FAIL wrap_pre actual=%0d required=1022", wptr);
        end
        run_burst(4, 1, 999, 0, 1'b0, 1'b0, c);
        checks++;
        if (wptr !== 10'd2 || exp_ptr !== 2) begin
            errors++;
            $display("FAIL wrap_post actual=%0d required=2", wptr);
        end
    endtask

    task automatic test_random();
        int c;
        for (int b = 0; b < 6; b++) begin
            run_burst($urandom_range(1, 40), $urandom_range(0, 4), $urandom_range(0, 10),
                      $urandom_range(0, 4), 1'b1, 1'($urandom), c);
        end
    endtask

    task automatic test_mid_reset();
        int c;
        burst_start = 1'b1;
        burst_len   = 8'd6;
        cyc();
        burst_start = 1'b0;
        wack        = 1'b1;
        cyc();
        wack        = 1'b0;
        for (int k = 0; k < 2; k++) begin
            src_valid = 1'b1;
            src_data  = 8'($urandom);
            @(negedge wclk);
            checks++;
            if (winc !== 1'b1 || waddr !== 10'(exp_ptr)) begin
                errors++;
                $display("FAIL midrst_write actual winc=%b waddr=%0d required 1 %0d", winc, waddr, exp_ptr);
            end
            exp_ptr = (exp_ptr + 1) % 1024;
            cyc();
        end
        wrst = 1'b1;
        cyc();
        wrst = 1'b0;
        src_valid = 1'b0;
        exp_ptr = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            checks++;
            if (wen !== 0 || wptr !== 0 || burst_done !== 0 || winc !== 0 || widle !== 2'b01) begin
                errors++;
                $display("FAIL midrst_state actual wen=%b wptr=%0d done=%b winc=%b widle=%b required 0 0 0 0 01",
                         wen, wptr, burst_done, winc, widle);
            end
            cyc();
        end
        run_burst(0, 1, 999, 0, 1'b0, 1'b0, c);
        checks++;
        if (c !== 256 || wptr !== 10'd256) begin
            errors++;
            $display("FAIL len_zero actual cycles=%0d wptr=%0d required 256 256", c, wptr);
        end
    endtask

    initial begin
        wrst        = 1'b1;
        burst_start = 1'b0;
        burst_len   = 8'd0;
        src_valid   = 1'b0;
        src_data    = 8'd0;
        wack        = 1'b0;
        wfull       = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_full_stall();
        test_ignored();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
